// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with the MEM/WB pipeline register.
// The EX/MEM ALU result is the byte address and reg_2 is the store data.
// Byte, half and word loads and stores go to an internal little-endian data RAM.
// Load data is aligned and extended before it is registered for write-back.
// Optional feature: define MEM_STAGE_DBG_PORT_EN to add a combinational debug
// read port (o_dbg_data = RAM[i_dbg_addr]). When it is not defined, o_dbg_data is 0
// and no second read port is built.
module mem_access_stage #(
  parameter int len     = 32,
  parameter int NB_addr = 10,
  parameter int NB_reg  = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic [len-1:0]     i_alu_result,
  input  logic [len-1:0]     i_reg_2,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [1:0]         i_width,
  input  logic               i_unsigned,
  input  logic               i_reg_write,
  input  logic               i_mem_to_reg,
  input  logic [NB_reg-1:0]  i_rd,
  input  logic [NB_addr-1:0] i_dbg_addr,
  output logic [len-1:0]     o_read_data,
  output logic [len-1:0]     o_alu_result,
  output logic [NB_reg-1:0]  o_rd,
  output logic               o_reg_write,
  output logic               o_mem_to_reg,
  output logic               o_valid,
  output logic               o_misaligned,
  output logic [len-1:0]     o_dbg_data
);

  localparam int DEPTH   = 2 ** NB_addr;
  localparam int NB_LANE = len / 8;

  logic [len-1:0]     ram [DEPTH];

  logic [NB_addr-1:0] word_idx;
  logic [1:0]         byte_off;
  logic               is_byte;
  logic               is_half;
  logic               is_word;
  logic               misaligned;
  logic               do_store;
  logic [len-1:0]     ram_word;
  logic [7:0]         load_byte;
  logic [15:0]        load_half;
  logic [len-1:0]     load_data;
  logic [len-1:0]     store_data;
  logic [NB_LANE-1:0] byte_en;

  // Upper address bits are dropped, so addresses wrap around the RAM size.
  assign word_idx = i_alu_result[NB_addr+1:2];
  assign byte_off = i_alu_result[1:0];
  assign is_byte  = (i_width == 2'b00);
  assign is_half  = (i_width == 2'b01);
  assign is_word  = i_width[1];

  assign misaligned = (i_mem_read || i_mem_write) &&
                      ((is_half && byte_off[0]) || (is_word && (byte_off != 2'b00)));
  assign do_store   = i_enable && i_valid && i_mem_write && !misaligned;

  // Combinational read, lane alignment, extension and store lane selection.
  always_comb begin
    ram_word  = ram[word_idx];
    load_byte = ram_word[{byte_off, 3'b000} +: 8];
    load_half = byte_off[1] ? ram_word[31:16] : ram_word[15:0];
    load_data = '0;
    if (i_mem_read && !i_mem_write && !misaligned) begin
      if (is_byte) begin
        load_data = i_unsigned ? {{(len-8){1'b0}}, load_byte}
                               : {{(len-8){load_byte[7]}}, load_byte};
      end else if (is_half) begin
        load_data = i_unsigned ? {{(len-16){1'b0}}, load_half}
                               : {{(len-16){load_half[15]}}, load_half};
      end else begin
        load_data = ram_word;
      end
    end

    store_data = i_reg_2;
    byte_en    = '1;
    if (is_byte) begin
      store_data = {NB_LANE{i_reg_2[7:0]}};
      byte_en    = NB_LANE'(1) << byte_off;
    end else if (is_half) begin
      store_data = {(len/16){i_reg_2[15:0]}};
      byte_en    = NB_LANE'(3) << {byte_off[1], 1'b0};
    end
  end

  // RAM write port; a reset that is high at the edge cancels the store.
  always_ff @(posedge i_clk) begin
    if (do_store && !i_rst) begin
      for (int k = 0; k < NB_LANE; k++) begin
        if (byte_en[k]) begin
          ram[word_idx][8*k +: 8] <= store_data[8*k +: 8];
        end
      end
    end
  end

  // MEM/WB register: holds during freeze; bad or empty slots never write back.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_rd         <= '0;
      o_reg_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
    end else if (i_enable) begin
      o_read_data  <= load_data;
      o_alu_result <= i_alu_result;
      o_rd         <= i_rd;
      o_reg_write  <= i_valid && i_reg_write && !misaligned;
      o_mem_to_reg <= i_mem_to_reg;
      o_valid      <= i_valid;
      o_misaligned <= i_valid && misaligned;
    end
  end

`ifdef MEM_STAGE_DBG_PORT_EN
  assign o_dbg_data = ram[i_dbg_addr];
`else
  logic dbg_unused;
  assign dbg_unused = ^i_dbg_addr;
  assign o_dbg_data = '0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and randomized checks of mem_access_stage
// against a byte-addressed memory model.
module tb_mem_access_stage;

  localparam int LEN      = 32;
  localparam int NB_ADDR  = 10;
  localparam int NB_REG   = 5;
  localparam int MEMBYTES = 4 * (2 ** NB_ADDR);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               valid = 1'b0;
  logic [LEN-1:0]     alu_result = '0;
  logic [LEN-1:0]     reg_2 = '0;
  logic               mem_read = 1'b0;
  logic               mem_write = 1'b0;
  logic [1:0]         width = 2'b00;
  logic               unsgn = 1'b0;
  logic               reg_write = 1'b0;
  logic               mem_to_reg = 1'b0;
  logic [NB_REG-1:0]  rd = '0;
  logic [NB_ADDR-1:0] dbg_addr = '0;
  logic [LEN-1:0]     read_data_o;
  logic [LEN-1:0]     alu_result_o;
  logic [NB_REG-1:0]  rd_o;
  logic               reg_write_o;
  logic               mem_to_reg_o;
  logic               valid_o;
  logic               misaligned_o;
  logic [LEN-1:0]     dbg_data_o;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mdl [MEMBYTES];
  logic [31:0] e_rdata;
  logic [31:0] e_alu;
  logic [4:0]  e_rd;
  logic        e_regw;
  logic        e_m2r;
  logic        e_valid;
  logic        e_mis;

  mem_access_stage #(.len(LEN), .NB_addr(NB_ADDR), .NB_reg(NB_REG)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_valid(valid),
    .i_alu_result(alu_result), .i_reg_2(reg_2), .i_mem_read(mem_read),
    .i_mem_write(mem_write), .i_width(width), .i_unsigned(unsgn),
    .i_reg_write(reg_write), .i_mem_to_reg(mem_to_reg), .i_rd(rd),
    .i_dbg_addr(dbg_addr), .o_read_data(read_data_o), .o_alu_result(alu_result_o),
    .o_rd(rd_o), .o_reg_write(reg_write_o), .o_mem_to_reg(mem_to_reg_o),
    .o_valid(valid_o), .o_misaligned(misaligned_o), .o_dbg_data(dbg_data_o)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  // Reference load: gather bytes little-endian, then extend by access size.
  function automatic logic [31:0] mload(input logic [31:0] a, input logic [1:0] w, input bit u);
    int ba = int'(a % MEMBYTES);
    int n = nbytes(w);
    logic [31:0] v = 0;
    logic [31:0] mask;
    for (int i = 0; i < n; i++) v = v | (32'(mdl[ba + i]) << (8 * i));
    if (n < 4 && !u && v[8*n-1]) begin
      mask = (32'h1 << (8 * n)) - 1;
      v = v | ~mask;
    end
    return v;
  endfunction

  task automatic mstore(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    int ba = int'(a % MEMBYTES);
    for (int i = 0; i < nbytes(w); i++) mdl[ba + i] = d[8*i +: 8];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".read_data"}, read_data_o, e_rdata);
    checkOutput({tag, ".alu_result"}, alu_result_o, e_alu);
    checkOutput({tag, ".rd"}, 32'(rd_o), 32'(e_rd));
    checkOutput({tag, ".reg_write"}, 32'(reg_write_o), 32'(e_regw));
    checkOutput({tag, ".mem_to_reg"}, 32'(mem_to_reg_o), 32'(e_m2r));
    checkOutput({tag, ".valid"}, 32'(valid_o), 32'(e_valid));
    checkOutput({tag, ".misaligned"}, 32'(misaligned_o), 32'(e_mis));
  endtask

  task automatic checkDbg(input string tag, input logic [NB_ADDR-1:0] idx);
    dbg_addr = idx;
    #1;
`ifdef MEM_STAGE_DBG_PORT_EN
    checkOutput(tag, dbg_data_o, mload({20'b0, idx, 2'b00}, 2'd2, 1'b1));
`else
    checkOutput(tag, dbg_data_o, 32'h0);
`endif
  endtask

  task automatic clearExpected();
    e_rdata = 0; e_alu = 0; e_rd = 0; e_regw = 0; e_m2r = 0; e_valid = 0; e_mis = 0;
  endtask

  // One instruction slot: drive, predict, clock, compare.
  task automatic applyStimulus(input string tag, input bit en, input bit v,
                               input logic [31:0] a, input logic [31:0] d,
                               input bit r, input bit wr, input logic [1:0] w,
                               input bit u, input bit rw, input bit m2r,
                               input logic [4:0] dst);
    bit mis;
    enable = en; valid = v; alu_result = a; reg_2 = d; mem_read = r; mem_write = wr;
    width = w; unsgn = u; reg_write = rw; mem_to_reg = m2r; rd = dst;
    mis = (r || wr) && ((w == 2'd1 && a[0]) || (w[1] && a[1:0] != 2'b00));
    if (en) begin
      e_rdata = (r && !wr && !mis) ? mload(a, w, u) : 32'h0;
      e_alu = a; e_rd = dst; e_regw = v && rw && !mis;
      e_m2r = m2r; e_valid = v; e_mis = v && mis;
    end
    @(posedge clk);
    if (en && v && wr && !mis) mstore(a, d, w);
    #1;
    checkAll(tag);
  endtask

  task automatic sw(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    applyStimulus(tag, 1, 1, a, d, 0, 1, w, 0, 0, 0, 5'd0);
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [1:0] w, input bit u);
    applyStimulus(tag, 1, 1, a, 32'h0, 1, 0, w, u, 1, 1, 5'd9);
  endtask

  initial begin
    logic [31:0] ra;
    int          kind;
    clearExpected();
    #12;
    checkAll("reset_init");
    rst = 1'b0;

    // Word store then load next cycle.
    sw("sw10", 32'h10, 32'hDEADBEEF, 2'd2);
    ld("lw10", 32'h10, 2'd2, 0);

    // Byte store into a known word; signed, unsigned, then whole word.
    sw("sw20", 32'h20, 32'h11223344, 2'd2);
    sw("sb21", 32'h21, 32'hAAAAAA80, 2'd0);
    ld("lb21", 32'h21, 2'd0, 0);
    ld("lbu21", 32'h21, 2'd0, 1);
    ld("lw20", 32'h20, 2'd2, 0);
    checkOutput("lw20_value", read_data_o, 32'h11228044);

    // Half store/load and misaligned cases.
    sw("sh22", 32'h22, 32'h55558001, 2'd1);
    ld("lh22", 32'h22, 2'd1, 0);
    checkOutput("lh22_value", read_data_o, 32'hFFFF8001);
    ld("lhu22", 32'h22, 2'd1, 1);
    ld("lw13_mis", 32'h13, 2'd2, 0);
    applyStimulus("sw12_mis", 1, 1, 32'h12, 32'h99999999, 0, 1, 2'd2, 0, 1, 0, 5'd4);
    applyStimulus("sh11_mis", 1, 1, 32'h11, 32'h77777777, 0, 1, 2'd1, 0, 1, 0, 5'd4);
    ld("lw10_after_mis", 32'h10, 2'd2, 0);
    applyStimulus("rw_both", 1, 1, 32'h24, 32'h0BADF00D, 1, 1, 2'd2, 0, 1, 1, 5'd7);
    ld("lw24", 32'h24, 2'd2, 0);
    applyStimulus("rtype", 1, 1, 32'h12345678, 32'h0, 0, 0, 2'd2, 0, 1, 0, 5'd3);
    applyStimulus("invalid_sw", 1, 0, 32'h24, 32'h66666666, 0, 1, 2'd2, 0, 1, 0, 5'd2);
    ld("lw24_keep", 32'h24, 2'd2, 0);

    // Freeze while a store is presented, then let it through.
    sw("sw80", 32'h80, 32'h01020304, 2'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("freeze", 0, 1, 32'h80, 32'hCAFEF00D, 0, 1, 2'd2, 0, 0, 0, 5'd1);
      checkDbg("dbg_freeze", 10'h20);
    end
    ld("lw80_frozen", 32'h80, 2'd2, 0);
    sw("sw80_go", 32'h80, 32'hCAFEF00D, 2'd2);
    ld("lw80_new", 32'h80, 2'd2, 0);

    // Address wrap past the top of the RAM.
    sw("sw_wrap", MEMBYTES, 32'hA5A55A5A, 2'd2);
    ld("lw0_wrap", 32'h0, 2'd2, 0);
    checkDbg("dbg_wrap", 10'h0);

    // Reset asserted mid-cycle with a store pending.
    sw("sw40", 32'h40, 32'h11111111, 2'd2);
    enable = 1; valid = 1; alu_result = 32'h40; reg_2 = 32'h22222222;
    mem_read = 0; mem_write = 1; width = 2'd2; reg_write = 1;
    #3 rst = 1'b1;
    #1;
    clearExpected();
    checkAll("reset_mid");
    @(posedge clk);
    #1;
    checkAll("reset_held");
    rst = 1'b0;
    ld("lw40_after_rst", 32'h40, 2'd2, 0);

    // Seed a pool of words, then random traffic over it.
    for (int i = 0; i < 8; i++) sw("seed", 32'h100 + 32'(4 * i), $urandom, 2'd2);
    for (int i = 0; i < 200; i++) begin
      ra = ($urandom & 32'hFFFFF000) | (32'h100 + 32'($urandom_range(0, 31)));
      kind = $urandom_range(0, 3);
      applyStimulus("rand", $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, ra, $urandom,
                    kind[0], kind[1], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
